// File: rtl/sphere_array_intersect.sv
// Ray vs. sphere-table intersection: scans every enabled sphere through a
// 2-stage fixed-point pipeline and reports the nearest hit in front of the origin.

package fixed_point;
  localparam int FIXED_W = 32;
  localparam int FRAC_W  = 16;

  typedef logic signed [FIXED_W-1:0] fixed_point_t;
  typedef struct packed {
    fixed_point_t v;
    logic         ovf;
  } fp_res_t;

  // The double-width product exists only inside the multiplier; results are
  // rescaled back to FIXED_W and flagged if they no longer fit.
  function automatic fp_res_t mul(input fixed_point_t a, input fixed_point_t b);
    logic signed [2*FIXED_W-1:0] full;
    logic signed [2*FIXED_W-1:0] scaled;
    fp_res_t r;
    full   = $signed({{FIXED_W{a[FIXED_W-1]}}, a}) * $signed({{FIXED_W{b[FIXED_W-1]}}, b});
    scaled = full >>> FRAC_W;
    r.v    = scaled[FIXED_W-1:0];
    r.ovf  = (scaled[2*FIXED_W-1:FIXED_W-1] != {(FIXED_W+1){scaled[FIXED_W-1]}});
    return r;
  endfunction

  function automatic fp_res_t add(input fixed_point_t a, input fixed_point_t b);
    fp_res_t r;
    r.v   = a + b;
    r.ovf = (a[FIXED_W-1] == b[FIXED_W-1]) && (r.v[FIXED_W-1] != a[FIXED_W-1]);
    return r;
  endfunction

  function automatic fp_res_t sub(input fixed_point_t a, input fixed_point_t b);
    fp_res_t r;
    r.v   = a - b;
    r.ovf = (a[FIXED_W-1] != b[FIXED_W-1]) && (r.v[FIXED_W-1] != a[FIXED_W-1]);
    return r;
  endfunction
endpackage

package vector;
  typedef struct packed {
    fixed_point::fixed_point_t x;
    fixed_point::fixed_point_t y;
    fixed_point::fixed_point_t z;
  } vector_t;

  function automatic fixed_point::fp_res_t dot(input vector_t a, input vector_t b);
    fixed_point::fp_res_t px, py, pz, s1, s2, r;
    px    = fixed_point::mul(a.x, b.x);
    py    = fixed_point::mul(a.y, b.y);
    pz    = fixed_point::mul(a.z, b.z);
    s1    = fixed_point::add(px.v, py.v);
    s2    = fixed_point::add(s1.v, pz.v);
    r.v   = s2.v;
    r.ovf = px.ovf | py.ovf | pz.ovf | s1.ovf | s2.ovf;
    return r;
  endfunction
endpackage

module sphere_array_intersect #(
  parameter  int NUM_SPHERES = 4,
  localparam int IDX_W       = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
  input  logic                      pixel_clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  vector::vector_t           cfg_center,
  input  fixed_point::fixed_point_t cfg_radius,
  input  logic                      ray_valid,
  output logic                      ray_ready,
  input  vector::vector_t           ray,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_hit,
  output logic [IDX_W-1:0]          res_idx,
  output logic [NUM_SPHERES-1:0]    res_mask,
  output fixed_point::fixed_point_t res_tca,
  output logic                      res_overflow
);
  import fixed_point::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPHERES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state_q, state_d;
  vector::vector_t         center_q [NUM_SPHERES];
  fixed_point_t            radius_q [NUM_SPHERES];
  logic [NUM_SPHERES-1:0]  en_q;
  vector::vector_t         ray_q;

  logic                    issue_busy_q;
  logic [IDX_W-1:0]        issue_idx_q;

  logic                    a_vld_q, a_en_q, a_ovf_q;
  logic [IDX_W-1:0]        a_idx_q;
  fixed_point_t            a_tca_q, a_m_q, a_r2_q;

  logic                    b_vld_q, b_en_q, b_ovf_q, b_disc_neg_q;
  logic [IDX_W-1:0]        b_idx_q;
  fixed_point_t            b_tca_q;

  logic                    hit_q, ovf_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_SPHERES-1:0]  mask_q;
  fixed_point_t            tca_q;

  logic    accept, cfg_wr, b_last, entry_hit;
  fp_res_t tca_r, m_r, r2_r, tt_r, mr_r, disc_r;

  assign accept    = ray_valid && ray_ready;
  assign cfg_wr    = cfg_we && (state_q == IDLE) && (32'(cfg_idx) < 32'(NUM_SPHERES));
  assign b_last    = (b_idx_q == LAST_IDX);
  assign entry_hit = b_vld_q && b_en_q && !b_disc_neg_q && (b_tca_q > 0) && !b_ovf_q;

  always_comb begin
    tca_r  = vector::dot(ray_q, center_q[issue_idx_q]);
    m_r    = vector::dot(center_q[issue_idx_q], center_q[issue_idx_q]);
    r2_r   = mul(radius_q[issue_idx_q], radius_q[issue_idx_q]);
    tt_r   = mul(a_tca_q, a_tca_q);
    mr_r   = sub(a_m_q, a_r2_q);
    disc_r = sub(tt_r.v, mr_r.v);
  end

  always_comb begin
    state_d   = state_q;
    ray_ready = (state_q == IDLE);
    case (state_q)
      IDLE:    if (ray_valid)          state_d = SCAN;
      SCAN:    if (b_vld_q && b_last)  state_d = DONE;
      DONE:    if (res_ready)          state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Table writes are only honoured while idle, so a scan always sees a frozen table.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
      for (int i = 0; i < NUM_SPHERES; i++) begin
        center_q[i] <= '0;
        radius_q[i] <= '0;
      end
    end else if (cfg_wr) begin
      center_q[cfg_idx] <= cfg_center;
      radius_q[cfg_idx] <= cfg_radius;
      en_q[cfg_idx]     <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      ray_q        <= '0;
      issue_busy_q <= 1'b0;
      issue_idx_q  <= '0;
      a_vld_q      <= 1'b0;
      a_en_q       <= 1'b0;
      a_ovf_q      <= 1'b0;
      a_idx_q      <= '0;
      a_tca_q      <= '0;
      a_m_q        <= '0;
      a_r2_q       <= '0;
      b_vld_q      <= 1'b0;
      b_en_q       <= 1'b0;
      b_ovf_q      <= 1'b0;
      b_disc_neg_q <= 1'b0;
      b_idx_q      <= '0;
      b_tca_q      <= '0;
    end else begin
      if (accept) begin
        ray_q        <= ray;
        issue_busy_q <= 1'b1;
        issue_idx_q  <= '0;
      end else if (issue_busy_q) begin
        if (issue_idx_q == LAST_IDX) issue_busy_q <= 1'b0;
        else                         issue_idx_q  <= issue_idx_q + 1'b1;
      end
      a_vld_q      <= issue_busy_q;
      a_en_q       <= en_q[issue_idx_q];
      a_idx_q      <= issue_idx_q;
      a_tca_q      <= tca_r.v;
      a_m_q        <= m_r.v;
      a_r2_q       <= r2_r.v;
      a_ovf_q      <= tca_r.ovf | m_r.ovf | r2_r.ovf;
      b_vld_q      <= a_vld_q;
      b_en_q       <= a_en_q;
      b_idx_q      <= a_idx_q;
      b_tca_q      <= a_tca_q;
      b_disc_neg_q <= disc_r.v[FIXED_W-1];
      b_ovf_q      <= a_ovf_q | tt_r.ovf | mr_r.ovf | disc_r.ovf;
    end
  end

  // Entries retire in ascending index order, so a strict compare keeps the lower index on ties.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hit_q  <= 1'b0;
      ovf_q  <= 1'b0;
      idx_q  <= '0;
      mask_q <= '0;
      tca_q  <= '0;
    end else if (accept) begin
      hit_q  <= 1'b0;
      ovf_q  <= 1'b0;
      idx_q  <= '0;
      mask_q <= '0;
      tca_q  <= '0;
    end else if (b_vld_q) begin
      if (b_en_q && b_ovf_q) ovf_q <= 1'b1;
      if (entry_hit) begin
        mask_q[b_idx_q] <= 1'b1;
        if (!hit_q || (b_tca_q < tca_q)) begin
          hit_q <= 1'b1;
          idx_q <= b_idx_q;
          tca_q <= b_tca_q;
        end
      end
    end
  end

  assign res_valid    = (state_q == DONE);
  assign res_hit      = res_valid & hit_q;
  assign res_idx      = res_valid ? idx_q  : '0;
  assign res_mask     = res_valid ? mask_q : '0;
  assign res_tca      = res_valid ? tca_q  : '0;
  assign res_overflow = res_valid & ovf_q;
endmodule

// File: tb/tb_sphere_array_intersect.sv
// Directed scoreboard bench for sphere_array_intersect (NUM_SPHERES=4, Q16.16).
module tb_sphere_array_intersect;
  import fixed_point::*;
  import vector::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam fixed_point_t ONE  = 32'sh0001_0000;
  localparam fixed_point_t MAXV = 32'sh7fff_ffff;

  logic            pixel_clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [IW-1:0]   cfg_idx;
  vector_t         cfg_center;
  fixed_point_t    cfg_radius;
  logic            ray_valid;
  logic            ray_ready;
  vector_t         ray;
  logic            res_valid;
  logic            res_ready;
  logic            res_hit;
  logic [IW-1:0]   res_idx;
  logic [N-1:0]    res_mask;
  fixed_point_t    res_tca;
  logic            res_overflow;

  typedef struct {
    logic          hit;
    logic [IW-1:0] idx;
    logic [N-1:0]  mask;
    fixed_point_t  tca;
    logic          ovf;
  } exp_t;

  exp_t expQ[$];
  int   compared    = 0;
  int   mismatched  = 0;
  int   cycle       = 0;
  int   acceptCycle = 0;

  sphere_array_intersect #(.NUM_SPHERES(N)) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_center  (cfg_center),
    .cfg_radius  (cfg_radius),
    .ray_valid   (ray_valid),
    .ray_ready   (ray_ready),
    .ray         (ray),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_hit     (res_hit),
    .res_idx     (res_idx),
    .res_mask    (res_mask),
    .res_tca     (res_tca),
    .res_overflow(res_overflow)
  );

  always #5 pixel_clk = ~pixel_clk;
  always @(posedge pixel_clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic vector_t vec(input int x, input int y, input int z);
    vector_t v;
    v.x = fixed_point_t'(x * 65536);
    v.y = fixed_point_t'(y * 65536);
    v.z = fixed_point_t'(z * 65536);
    return v;
  endfunction

  function automatic exp_t mkExp(input logic hit, input int idx, input int mask,
                                 input int tcaInt, input logic ovf);
    exp_t e;
    e.hit  = hit;
    e.idx  = IW'(idx);
    e.mask = N'(mask);
    e.tca  = fixed_point_t'(tcaInt * 65536);
    e.ovf  = ovf;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic resetDut();
    @(negedge pixel_clk);
    rst = 1'b1;
    @(negedge pixel_clk);
    rst = 1'b0;
  endtask

  task automatic writeEntry(input int idx, input vector_t c, input fixed_point_t r);
    @(negedge pixel_clk);
    cfg_we     = 1'b1;
    cfg_idx    = IW'(idx);
    cfg_center = c;
    cfg_radius = r;
    @(negedge pixel_clk);
    cfg_we     = 1'b0;
  endtask

  // Offers a ray (optionally with a table write on the same edge) and records
  // the expected result on the scoreboard at the moment of acceptance.
  task automatic applyStimulus(input vector_t dir, input exp_t e, input bit pushExp,
                               input bit doWrite, input int wIdx, input vector_t wC,
                               input fixed_point_t wR);
    int w = 0;
    @(negedge pixel_clk);
    while (!ray_ready && w < 20) begin
      @(negedge pixel_clk);
      w++;
    end
    checkOutput("ray_ready_idle", 64'(ray_ready), 64'(1));
    ray_valid = 1'b1;
    ray       = dir;
    if (doWrite) begin
      cfg_we     = 1'b1;
      cfg_idx    = IW'(wIdx);
      cfg_center = wC;
      cfg_radius = wR;
    end
    if (pushExp) expQ.push_back(e);
    @(posedge pixel_clk);
    #1;
    acceptCycle = cycle;
    ray_valid   = 1'b0;
    cfg_we      = 1'b0;
    checkOutput("ray_ready_busy", 64'(ray_ready), 64'(0));
  endtask

  task automatic collectResult(input int holdCycles);
    int   w = 0;
    exp_t e;
    while (!res_valid && w < 40) begin
      @(posedge pixel_clk);
      #1;
      w++;
    end
    checkOutput("res_valid_seen", 64'(res_valid), 64'(1));
    checkOutput("latency", 64'(cycle - acceptCycle), 64'(N + 2));
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_nonempty", 64'(expQ.size()), 64'(1));
      return;
    end
    e = expQ.pop_front();
    for (int k = 0; k <= holdCycles; k++) begin
      if (k > 0) begin
        @(posedge pixel_clk);
        #1;
        checkOutput("hold_valid", 64'(res_valid), 64'(1));
        checkOutput("hold_ray_ready", 64'(ray_ready), 64'(0));
      end
      checkOutput("res_hit", 64'(res_hit), 64'(e.hit));
      checkOutput("res_idx", 64'(res_idx), 64'(e.idx));
      checkOutput("res_mask", 64'(res_mask), 64'(e.mask));
      checkOutput("res_tca", 64'(res_tca), 64'(e.tca));
      checkOutput("res_overflow", 64'(res_overflow), 64'(e.ovf));
    end
    @(negedge pixel_clk);
    res_ready = 1'b1;
    @(posedge pixel_clk);
    #1;
    res_ready = 1'b0;
    checkOutput("ray_ready_after_hs", 64'(ray_ready), 64'(1));
    checkOutput("res_valid_after_hs", 64'(res_valid), 64'(0));
  endtask

  initial begin
    vector_t dirZ;
    int      seen;
    dirZ       = vec(0, 0, 1);
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_center = '0;
    cfg_radius = '0;
    ray_valid  = 1'b0;
    ray        = '0;
    res_ready  = 1'b0;
    repeat (2) @(negedge pixel_clk);
    rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_res_valid", 64'(res_valid), 64'(0));
    checkOutput("rst_ray_ready", 64'(ray_ready), 64'(1));
    checkOutput("rst_res_hit", 64'(res_hit), 64'(0));
    checkOutput("rst_res_mask", 64'(res_mask), 64'(0));
    checkOutput("rst_res_tca", 64'(res_tca), 64'(0));
    checkOutput("rst_res_overflow", 64'(res_overflow), 64'(0));

    $display("[TB] single sphere ahead");
    writeEntry(0, vec(0, 0, 5), ONE);
    applyStimulus(dirZ, mkExp(1, 0, 4'b0001, 5, 0), 1, 0, 0, '0, '0);
    collectResult(0);

    $display("[TB] nearest of three, held for 10 cycles");
    writeEntry(1, vec(0, 0, 3), ONE);
    writeEntry(2, vec(0, 0, -5), ONE);
    applyStimulus(dirZ, mkExp(1, 1, 4'b0011, 3, 0), 1, 0, 0, '0, '0);
    collectResult(10);

    $display("[TB] write during scan is dropped");
    applyStimulus(dirZ, mkExp(1, 1, 4'b0011, 3, 0), 1, 0, 0, '0, '0);
    writeEntry(3, vec(0, 0, 2), ONE);
    collectResult(0);
    applyStimulus(dirZ, mkExp(1, 1, 4'b0011, 3, 0), 1, 0, 0, '0, '0);
    collectResult(0);

    $display("[TB] miss with negative discriminant");
    resetDut();
    writeEntry(0, vec(3, 0, 5), ONE);
    applyStimulus(dirZ, mkExp(0, 0, 4'b0000, 0, 0), 1, 0, 0, '0, '0);
    collectResult(0);

    $display("[TB] write on accepting edge is seen");
    resetDut();
    applyStimulus(dirZ, mkExp(1, 0, 4'b0001, 5, 0), 1, 1, 0, vec(0, 0, 5), ONE);
    collectResult(0);

    $display("[TB] reset mid-scan abandons ray");
    applyStimulus(dirZ, mkExp(1, 0, 4'b0001, 5, 0), 0, 0, 0, '0, '0);
    @(negedge pixel_clk);
    rst = 1'b1;
    @(negedge pixel_clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge pixel_clk);
      #1;
      if (res_valid) seen++;
    end
    checkOutput("abandon_no_valid", 64'(seen), 64'(0));
    applyStimulus(dirZ, mkExp(0, 0, 4'b0000, 0, 0), 1, 0, 0, '0, '0);
    collectResult(0);
    writeEntry(0, vec(0, 0, 5), ONE);
    applyStimulus(dirZ, mkExp(1, 0, 4'b0001, 5, 0), 1, 0, 0, '0, '0);
    collectResult(0);

    $display("[TB] overflowing entry excluded, tie keeps lower index");
    writeEntry(1, '{x: MAXV, y: '0, z: '0}, ONE);
    applyStimulus(dirZ, mkExp(1, 0, 4'b0001, 5, 1), 1, 0, 0, '0, '0);
    collectResult(0);
    writeEntry(2, vec(0, 0, 5), ONE);
    applyStimulus(dirZ, mkExp(1, 0, 4'b0101, 5, 1), 1, 0, 0, '0, '0);
    collectResult(0);

    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
